// File: rtl/multi_pwm.sv
// Multi-channel PWM generator with a shared prescaler and counter, edge- or
// center-aligned counting, and double-buffered configuration that takes effect at period boundaries.
module multi_pwm #(
    parameter int CH      = 3,
    parameter int RES     = 10,
    parameter int PRESC_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [PRESC_W-1:0] presc,
    input  logic [RES-1:0]    period,
    input  logic [CH*RES-1:0] duty,
    input  logic              mode,
    input  logic              cfg_wr,
    input  logic [CH-1:0]     polarity,
    output logic [CH-1:0]     pwm_out,
    output logic              period_end,
    output logic              cfg_pending
);

    // A programmed period of zero behaves as a one-tick period.
    function automatic logic [RES-1:0] eff_period(input logic [RES-1:0] p);
        return (p == '0) ? RES'(1) : p;
    endfunction

    logic [PRESC_W-1:0] psc_q, psc_d;
    logic [RES-1:0]     cnt_q, cnt_d;
    logic               dir_q, dir_d;          // 1 = counting down (center mode)
    logic [RES-1:0]     per_a_q, per_a_d, per_p_q, per_p_d;
    logic [CH*RES-1:0]  duty_a_q, duty_a_d, duty_p_q, duty_p_d;
    logic               mode_a_q, mode_a_d, mode_p_q, mode_p_d;
    logic               pend_q, pend_d;
    logic               bnd_q, bnd_d;
    logic               pe_q, pe_d;
    logic [CH-1:0]      pwm_q, pwm_d;
    logic [CH-1:0]      raw;
    logic [RES-1:0]     p_last;
    logic               tick;
    logic               bnd;

    always_comb begin
        p_last = eff_period(per_a_q) - RES'(1);
        tick   = en && (psc_q >= presc);
        bnd    = 1'b0;
        if (tick) begin
            if (!mode_a_q) bnd = (cnt_q >= p_last);
            else           bnd = dir_q && (cnt_q == '0);
        end
    end

    always_comb begin
        psc_d = psc_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!en) begin
            psc_d = '0;
            cnt_d = '0;
            dir_d = 1'b0;
        end else if (tick) begin
            psc_d = '0;
            if (bnd) begin
                cnt_d = '0;
                dir_d = 1'b0;
            end else if (!mode_a_q) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!dir_q) begin
                // Top of the triangle: spend one extra tick at P-1 while turning around.
                if (cnt_q >= p_last) dir_d = 1'b1;
                else                 cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else begin
            psc_d = psc_q + 1'b1;
        end
    end

    always_comb begin
        per_a_d  = per_a_q;
        duty_a_d = duty_a_q;
        mode_a_d = mode_a_q;
        per_p_d  = per_p_q;
        duty_p_d = duty_p_q;
        mode_p_d = mode_p_q;
        pend_d   = pend_q;
        // Writes while stopped or exactly on a boundary bypass the pending stage.
        if (cfg_wr && (!en || bnd)) begin
            per_a_d  = period;
            duty_a_d = duty;
            mode_a_d = mode;
            pend_d   = 1'b0;
        end else if (bnd && pend_q) begin
            per_a_d  = per_p_q;
            duty_a_d = duty_p_q;
            mode_a_d = mode_p_q;
            pend_d   = 1'b0;
        end else if (cfg_wr) begin
            per_p_d  = period;
            duty_p_d = duty;
            mode_p_d = mode;
            pend_d   = 1'b1;
        end
    end

    always_comb begin
        raw = '0;
        for (int k = 0; k < CH; k++) begin
            raw[k] = (cnt_q < duty_a_q[k*RES +: RES]);
        end
        pwm_d = en ? (raw ^ polarity) : polarity;
        bnd_d = bnd;
        // Delayed one extra clock so the pulse lines up with the first output of the new period.
        pe_d  = bnd_q && en;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psc_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            per_a_q  <= '0;
            duty_a_q <= '0;
            mode_a_q <= 1'b0;
            per_p_q  <= '0;
            duty_p_q <= '0;
            mode_p_q <= 1'b0;
            pend_q   <= 1'b0;
            bnd_q    <= 1'b0;
            pe_q     <= 1'b0;
            pwm_q    <= '0;
        end else begin
            psc_q    <= psc_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            per_a_q  <= per_a_d;
            duty_a_q <= duty_a_d;
            mode_a_q <= mode_a_d;
            per_p_q  <= per_p_d;
            duty_p_q <= duty_p_d;
            mode_p_q <= mode_p_d;
            pend_q   <= pend_d;
            bnd_q    <= bnd_d;
            pe_q     <= pe_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_end  = pe_q;
    assign cfg_pending = pend_q;

endmodule

// File: doc/multi_pwm.md
MULTI_PWM -- requirements
Module: multi_pwm

Interface
REQ-001 SHALL provide parameter CH, default 3, number of PWM channels.
REQ-002 SHALL provide parameter RES, default 10, counter, period and duty width in bits.
REQ-003 SHALL provide parameter PRESC_W, default 16, prescaler width in bits.
REQ-004 SHALL provide port clk  input  1  single system clock; all state on its rising edge.
REQ-005 SHALL provide port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL provide port en  input  1  counter run enable.
REQ-007 SHALL provide port presc  input  PRESC_W  one tick every presc+1 clocks; not shadowed.
REQ-008 SHALL provide port period  input  RES  ticks per edge-mode period; value 0 treated as 1.
REQ-009 SHALL provide port duty  input  CH*RES  per-channel duty, channel k in bits [k*RES +: RES].
REQ-010 SHALL provide port mode  input  1  0 = edge-aligned, 1 = center-aligned.
REQ-011 SHALL provide port cfg_wr  input  1  one-clock strobe capturing period, duty and mode into pending registers.
REQ-012 SHALL provide port polarity  input  CH  per-channel output inversion; not shadowed.
REQ-013 SHALL provide port pwm_out  output  CH  registered PWM outputs.
REQ-014 SHALL provide port period_end  output  1  registered one-clock pulse at each period boundary.
REQ-015 SHALL provide port cfg_pending  output  1  high while captured config awaits a boundary.

Function
REQ-016 Prescaler SHALL count 0..presc while en=1 and SHALL generate tick and return to 0 when count equals presc; presc=0 gives a tick every clock.
REQ-017 Edge mode SHALL advance counter by 1 per tick over 0..P-1 (P = active period) and SHALL wrap to 0 on the tick at P-1; that tick is the boundary.
REQ-018 Center mode SHALL count up 0..P-1, hold P-1 for one extra tick while switching to down, count down to 0, hold 0 for one extra tick while switching to up; boundary is the tick on which direction switches down->up; period = 2P ticks.
REQ-019 Channel k raw level SHALL be (counter < active duty k); pwm_out[k] SHALL equal raw XOR polarity[k], registered, one clock after the counter value.
REQ-020 Duty 0 SHALL give constant inactive level; duty >= P SHALL give constant active level; center-mode high time SHALL be 2*duty ticks per 2P-tick period.
REQ-021 cfg_wr SHALL load pending registers and set cfg_pending; a later cfg_wr before the boundary SHALL overwrite pending (last write wins).
REQ-022 At a boundary tick with cfg_pending=1, active period, duty and mode SHALL load from pending and cfg_pending SHALL clear in the same clock.
REQ-023 If cfg_wr coincides with a boundary tick, the newly presented values SHALL load directly into active and cfg_pending SHALL be 0 afterwards.
REQ-024 period_end SHALL pulse high for exactly one clock, the clock after the boundary tick, aligned with the first pwm_out sample of the new period.
REQ-025 While en=0, prescaler and counter SHALL hold at 0 with direction up, pwm_out SHALL equal polarity, period_end SHALL be 0, and cfg_wr SHALL load active directly (cfg_pending stays 0).
REQ-026 On en 0->1, the first tick SHALL occur presc+1 clocks later, starting at counter 0.
REQ-027 en 1->0 mid-period SHALL abort the period at once with no period_end and no pending load; pending remains pending.

Reset
REQ-028 reset_n low SHALL immediately clear pwm_out, period_end, cfg_pending, prescaler, counter, direction (up), and active and pending period, duty and mode to 0.
REQ-029 Reset asserted mid-period SHALL discard all pending config; counting resumes from 0 per REQ-026 after reset_n rises with en=1.

Verification
REQ-030 CH=3, RES=8, presc=0, period=10, duty={10,0,3}, mode=0, polarity=0, cfg_wr then en=1 -> ch0 high 3 of every 10 clocks, ch1 always low, ch2 always high, period_end every 10 clocks.
REQ-031 mode=1, period=4, duty ch0=1 -> ch0 high 2 clocks per 8-clock period, centered on the 0-hold; period_end every 8 clocks.
REQ-032 Running duty ch0=3, cfg_wr duty 7 at counter 4 -> cfg_pending=1, ch0 keeps 3-clock pulse to period end, then 7-clock pulse, cfg_pending clears at boundary.
REQ-033 cfg_wr duty ch0=5 on the boundary tick -> 5-clock pulse in the immediately following period, cfg_pending never asserts.
REQ-034 presc=4, period=10 -> counter steps every 5 clocks, period_end every 50 clocks.
REQ-035 reset_n pulsed low mid-period with polarity=3'b111 -> pwm_out 0 asynchronously; after release with en=0, pwm_out=3'b111.
